plugboard: RTL and testbench
============================

// Module: plugboard
// PURPOSE
//  Enigma plugboard (Steckerbrett) stage directly upstream of the rotor. It swaps
//  letters in configured ASCII pairs (A..Z, 8'h41..8'h5A) and presents each result to
//  the rotor's din/valid inputs through a one-deep registered valid/ready output slot.
//  Pairs are loaded one per write; illegal pairs are rejected with an error pulse.
// PARAMETERS
//  MAX_PAIRS  10  maximum number of stored pairs, legal range 1..13
// PORTS
//  clk        in   1  single clock, rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  clr        in   1  clears all pairs: table returns to identity, pair count = 0
//  cfg_we     in   1  pair write strobe
//  cfg_a      in   8  first letter of the pair (ASCII)
//  cfg_b      in   8  second letter of the pair (ASCII)
//  cfg_err    out  1  one-cycle pulse: the write in the previous cycle was rejected
//  pair_cnt   out  4  number of pairs currently stored
//  valid      in   1  din is valid this cycle
//  din        in   8  input character (ASCII)
//  in_ready   out  1  the stage accepts din this cycle
//  dout       out  8  substituted character, drives rotor din
//  dout_valid out  1  dout is valid, drives rotor valid
//  ready      in   1  downstream consumes dout this cycle
// BEHAVIOUR
//  Reset: table = identity (map[i] = i for i = 0..25), pair_cnt = 0, cfg_err = 0,
//   dout = 8'h00, dout_valid = 0. Reset mid-transfer discards the held character.
//  Table: 26 entries of 5 bits each, holding letter indices 0..25 (letter = ASCII - 65).
//   A letter is "free" when map[x] == x.
//  Pair write (cfg_we = 1, clr = 0). The write is accepted only if all of these hold:
//   - cfg_a and cfg_b are both in A..Z;
//   - cfg_a != cfg_b;
//   - both letters are free;
//   - pair_cnt < MAX_PAIRS.
//  Accepted write: map[a] <= b, map[b] <= a, pair_cnt + 1, all on the next edge.
//  Rejected write: table and pair_cnt unchanged; cfg_err = 1 for exactly the next cycle.
//  clr: has priority over cfg_we. Table goes to identity and pair_cnt to 0 on the next
//   edge. cfg_err is not raised by clr.
//  Data FSM has two states:
//   - EMPTY: dout_valid = 0, in_ready = 1. When valid = 1, capture the substituted char
//     and go to FULL.
//   - FULL: dout_valid = 1, in_ready = ready.
//     - ready = 1 and valid = 1: load the new char and stay in FULL (back-to-back,
//       one char per cycle).
//     - ready = 1 and valid = 0: go to EMPTY.
//     - ready = 0: hold dout stable.
//  valid while in_ready = 0 is ignored. The source must hold its data.
//  Latency: exactly 1 clock from the accepting edge to dout_valid = 1.
//  Substitution: for din in A..Z, dout = map[din - 65] + 65. Any other byte passes
//   through unchanged (subject to PLUG_LOWER_EN).
//  Simultaneous events: data accepted in the same cycle as cfg_we or clr uses the table
//   contents from before that edge. dout is never altered while held.
//  The table can be rewritten while data is flowing; no stall is required.
// CONFIGURATION
//  PLUG_LOWER_EN
//   - Defined: din in a..z (8'h61..8'h7A) is folded to upper case, then substituted;
//     dout is always upper case. cfg_a and cfg_b are also folded before the legality
//     checks.
//   - Undefined: lower-case bytes pass through unchanged. Lower-case cfg letters are
//     illegal and produce cfg_err.
// TESTING
//  1. Reset, no writes; din = "A","Z","5" -> dout = "A","Z","5", each 1 cycle after
//     acceptance, pair_cnt = 0.
//  2. Write pair (A,Q); send "A","Q","B" -> dout = "Q","A","B"; pair_cnt = 1, no cfg_err.
//  3. After (A,Q), write (Q,C), (D,D), ("1",E) -> cfg_err pulses 3 times, pair_cnt
//     stays 1.
//  4. Write 10 legal pairs, then an 11th legal pair -> cfg_err = 1, pair_cnt = 10; clr
//     -> pair_cnt = 0 and "A" maps to "A".
//  5. ready = 0 for 4 cycles with "A" held; valid asserted -> dout stays "Q", in_ready
//     = 0; ready = 1 -> next char appears on the following cycle.
//  6. cfg_we (B,X) in the same cycle valid = 1 with din = "B" -> dout = "B"; a
//     following "B" -> "X".
//  7. With PLUG_LOWER_EN, pair (A,Q), din = "a" -> "Q"; without it, din = "a" -> "a".
//  8. Assert reset_n = 0 while dout_valid = 1 -> dout_valid = 0 and dout = 8'h00
//     immediately; table returns to identity.

Source files
------------

// File: rtl/plugboard.sv
// rtl/plugboard.sv - Enigma plugboard letter-pair substitution with a one-deep registered output slot.
// Optional PLUG_LOWER_EN folds lower-case data and pair letters to upper case.
module plugboard #(
    parameter int MAX_PAIRS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       cfg_we,
    input  logic [7:0] cfg_a,
    input  logic [7:0] cfg_b,
    output logic       cfg_err,
    output logic [3:0] pair_cnt,
    input  logic       valid,
    input  logic [7:0] din,
    output logic       in_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       ready
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_PAIRS);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state;
    logic [4:0] map_q [26];

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef PLUG_LOWER_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic logic [4:0] to_idx(input logic [7:0] c);
        return is_letter(c) ? 5'(c - 8'h41) : 5'd0;
    endfunction

    logic [7:0] ca, cb, dc, sub_c;
    logic [4:0] ia, ib, di;
    logic       legal, accept;

    always_comb begin
        ca    = fold(cfg_a);
        cb    = fold(cfg_b);
        ia    = to_idx(ca);
        ib    = to_idx(cb);
        legal = is_letter(ca) && is_letter(cb) && (ca != cb) &&
                (map_q[ia] == ia) && (map_q[ib] == ib) && (pair_cnt < MAX_CNT);
        dc    = fold(din);
        di    = to_idx(dc);
        sub_c = is_letter(dc) ? ({3'b000, map_q[di]} + 8'h41) : dc;
    end

    assign in_ready = (state == EMPTY) || ready;
    assign accept   = valid && in_ready;

    // Table updates land on the same edge that captures data, so captured data sees the old table.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 26; i++) map_q[i] <= 5'(i);
            pair_cnt <= 4'd0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !clr && !legal;
            if (clr) begin
                for (int i = 0; i < 26; i++) map_q[i] <= 5'(i);
                pair_cnt <= 4'd0;
            end else if (cfg_we && legal) begin
                map_q[ia] <= ib;
                map_q[ib] <= ia;
                pair_cnt  <= pair_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        dout       <= sub_c;
                        dout_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (ready && valid) begin
                        dout <= sub_c;
                    end else if (ready) begin
                        dout_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plugboard.sv
// tb/tb_plugboard.sv - Directed self-checking bench for plugboard.
module tb_plugboard;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_a = 8'h00;
    logic [7:0] cfg_b = 8'h00;
    logic       cfg_err;
    logic [3:0] pair_cnt;
    logic       valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       in_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       ready = 1'b1;

    int checks = 0;
    int errors = 0;

    plugboard #(.MAX_PAIRS(10)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_we(cfg_we), .cfg_a(cfg_a),
        .cfg_b(cfg_b), .cfg_err(cfg_err), .pair_cnt(pair_cnt), .valid(valid), .din(din),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] exp);
        int n;
        n = 0;
        valid = 1'b1;
        din   = c;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_timeout", in_ready, 1);
        tick();
        valid = 1'b0;
        check("send_dv", dout_valid, 1);
        check("send_dout", dout, exp);
        tick();
    endtask

    task automatic wp(input logic [7:0] a, input logic [7:0] b, input logic exp_err);
        cfg_we = 1'b1;
        cfg_a  = a;
        cfg_b  = b;
        tick();
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, exp_err);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_dout", dout, 8'h00);
        check("rst_dv", dout_valid, 0);
        check("rst_cnt", pair_cnt, 0);
        check("rst_err", cfg_err, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        tick();

        // identity
        send("A", "A");
        send("Z", "Z");
        send("5", "5");
        check("t1_cnt", pair_cnt, 0);

        // single pair
        wp("A", "Q", 1'b0);
        check("t2_cnt", pair_cnt, 1);
        send("A", "Q");
        send("Q", "A");
        send("B", "B");

        // illegal writes
        wp("Q", "C", 1'b1);
        wp("D", "D", 1'b1);
        wp("1", "E", 1'b1);
        tick();
        check("t3_err_clear", cfg_err, 0);
        check("t3_cnt", pair_cnt, 1);

        // backpressure
        ready = 1'b0;
        valid = 1'b1;
        din   = "A";
        tick();
        din   = "B";
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_dout", dout, "Q");
            check("t5_hold_dv", dout_valid, 1);
            check("t5_in_ready", in_ready, 0);
            tick();
        end
        ready = 1'b1;
        #1;
        check("t5_in_ready_up", in_ready, 1);
        tick();
        valid = 1'b0;
        check("t5_next", dout, "B");
        check("t5_next_dv", dout_valid, 1);
        tick();
        check("t5_drain", dout_valid, 0);

        // write and data in the same cycle
        cfg_we = 1'b1;
        cfg_a  = "B";
        cfg_b  = "X";
        valid  = 1'b1;
        din    = "B";
        tick();
        cfg_we = 1'b0;
        valid  = 1'b0;
        check("t6_old_table", dout, "B");
        check("t6_err", cfg_err, 0);
        tick();
        send("B", "X");
        check("t6_cnt", pair_cnt, 2);

        // capacity and clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_cnt", pair_cnt, 0);
        for (int i = 0; i < 10; i++) wp(8'(65 + 2 * i), 8'(66 + 2 * i), 1'b0);
        check("t4_full_cnt", pair_cnt, 10);
        wp("U", "V", 1'b1);
        check("t4_over_cnt", pair_cnt, 10);
        send("A", "B");
        send("T", "S");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr2_cnt", pair_cnt, 0);
        check("t4_clr_err", cfg_err, 0);
        send("A", "A");

        // lower case handling
        wp("A", "Q", 1'b0);
`ifdef PLUG_LOWER_EN
        send("a", "Q");
        wp("b", "c", 1'b0);
        send("C", "B");
`else
        send("a", "a");
        wp("b", "c", 1'b1);
        send("C", "C");
`endif

        // async reset while holding
        ready = 1'b0;
        valid = 1'b1;
        din   = "Z";
        tick();
        valid = 1'b0;
        check("t8_pre_dv", dout_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t8_dv", dout_valid, 0);
        check("t8_dout", dout, 8'h00);
        check("t8_cnt", pair_cnt, 0);
        ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        send("A", "A");
        send("Q", "Q");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
